// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_write_arbiter_pkg: shared types for the register-file write arb. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package regfile_write_arbiter_pkg;

  localparam int RF_XLEN  = 64;
  localparam int RF_REG_W = 5;
  localparam int RF_NREGS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [RF_REG_W-1:0] rd;
    logic [RF_XLEN-1:0]  data;
  } rf_entry_t;

  function automatic logic [RF_NREGS-1:0] rd_onehot(input logic [RF_REG_W-1:0] r);
    rd_onehot    = '0;
    rd_onehot[r] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wr_fifo: sync FIFO of secondary results with per-slot rd view.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module regfile_wr_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                push_i,
  input  rf_entry_t                           push_entry_i,
  input  logic                                pop_i,
  output rf_entry_t                           head_o,
  output logic                                full_o,
  output logic                                empty_o,
  output logic [$clog2(DEPTH):0]              count_o,
  output logic [DEPTH-1:0]                    entry_vld_o,
  output logic [DEPTH-1:0][RF_REG_W-1:0]      entry_rd_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  rf_entry_t        mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the write side has lapped the read side.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign count_o = wptr_q - rptr_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    vld_d  = vld_q;
    if (do_pop) begin
      rptr_d                 = rptr_q + 1'b1;
      vld_d[rptr_q[AW-1:0]]  = 1'b0;
    end
    if (do_push) begin
      wptr_d                 = wptr_q + 1'b1;
      vld_d[wptr_q[AW-1:0]]  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      vld_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      vld_q  <= vld_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= push_entry_i;
    end
  end

  assign entry_vld_o = vld_q;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
      assign entry_rd_o[i] = mem_q[i].rd;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_write_arbiter: shares the RF write port, primary-first with a    |
// | starvation-forced bubble for queued secondary results.  Rev 1.0          |
// +--------------------------------------------------------------------------+
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int XLEN       = RF_XLEN,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wb_valid,
  input  logic [RF_REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                lu_valid,
  output logic                lu_ready,
  input  logic [RF_REG_W-1:0] lu_rd,
  input  logic [XLEN-1:0]     lu_data,
  output logic                RegWrite,
  output logic [RF_REG_W-1:0] rd,
  output logic [XLEN-1:0]     Write_Data,
  output logic                stall_pipe,
  output logic [RF_NREGS-1:0] pending_mask,
  output logic                err_collision
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT - 1);

  logic                               wb_req;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic                               push;
  logic                               pop;
  logic                               next_empty;
  logic [AW:0]                        fifo_count;
  rf_entry_t                          push_entry;
  rf_entry_t                          head;
  logic [FIFO_DEPTH-1:0]              ent_vld;
  logic [FIFO_DEPTH-1:0][RF_REG_W-1:0] ent_rd;

  arb_state_e     state_q, state_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic           stall_q, stall_d;
  logic           err_q, err_d;

  // Writes to x0 are treated as empty slots and never claim the port.
  assign wb_req   = wb_valid && (wb_rd != '0);
  assign lu_ready = !fifo_full && !reset;
  assign push     = lu_valid && lu_ready && (lu_rd != '0);
  assign pop      = !reset && !wb_req && !fifo_empty;

  assign push_entry.rd   = lu_rd;
  assign push_entry.data = lu_data;

  regfile_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .entry_vld_o  (ent_vld),
    .entry_rd_o   (ent_rd)
  );

  always_comb begin
    next_empty = 1'b0;
    if (fifo_empty) begin
      next_empty = !push;
    end else begin
      next_empty = pop && !push && (fifo_count == (AW+1)'(1));
    end
  end

  always_comb begin
    RegWrite   = 1'b0;
    rd         = '0;
    Write_Data = '0;
    if (!reset) begin
      if (wb_req) begin
        RegWrite   = 1'b1;
        rd         = wb_rd;
        Write_Data = wb_data;
      end else if (!fifo_empty) begin
        RegWrite   = 1'b1;
        rd         = head.rd;
        Write_Data = head.data;
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i]) begin
        pending_mask = pending_mask | rd_onehot(ent_rd[i]);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (push) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fifo_empty) begin
          state_d    = push ? ST_WAIT : ST_IDLE;
          wait_cnt_d = '0;
        end else if (pop) begin
          state_d    = next_empty ? ST_IDLE : ST_WAIT;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d    = ST_FORCE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_FORCE: begin
        wait_cnt_d = '0;
        if (fifo_empty) begin
          state_d = push ? ST_WAIT : ST_IDLE;
        end else if (pop) begin
          state_d = next_empty ? ST_IDLE : ST_WAIT;
        end else begin
          // Pipeline ignored the bubble; keep stalling until the head drains.
          err_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase
    stall_d = (state_d == ST_FORCE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  assign stall_pipe    = stall_q;
  assign err_collision = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_write_arbiter: directed + random bench with queue model.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_regfile_write_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            RegWrite;
  logic [4:0]      rd;
  logic [XLEN-1:0] Write_Data;
  logic            stall_pipe;
  logic [31:0]     pending_mask;
  logic            err_collision;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   m_run   = 0;
  bit   m_stall = 1'b0;
  bit   m_err   = 1'b0;

  regfile_write_arbiter #(
    .XLEN       (XLEN),
    .FIFO_DEPTH (DEPTH),
    .MAX_WAIT   (MAXW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .lu_valid      (lu_valid),
    .lu_ready      (lu_ready),
    .lu_rd         (lu_rd),
    .lu_data       (lu_data),
    .RegWrite      (RegWrite),
    .rd            (rd),
    .Write_Data    (Write_Data),
    .stall_pipe    (stall_pipe),
    .pending_mask  (pending_mask),
    .err_collision (err_collision)
  );

  always #5 clock = ~clock;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at the falling edge against the model, then advance the model.
  task automatic step();
    bit              req;
    bit              exp_rdy;
    bit              exp_we;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;
    logic [31:0]     exp_mask;
    ent_t            e;
    @(negedge clock);
    req      = wb_valid && (wb_rd != 5'd0);
    exp_rdy  = !reset && (mq.size() < DEPTH);
    exp_we   = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
    if (!reset) begin
      if (req) begin
        exp_we = 1'b1; exp_rd = wb_rd; exp_data = wb_data;
      end else if (mq.size() > 0) begin
        exp_we = 1'b1; exp_rd = mq[0].rd; exp_data = mq[0].data;
      end
    end
    exp_mask = '0;
    foreach (mq[i]) exp_mask[mq[i].rd] = 1'b1;
    chk_val("RegWrite", RegWrite, exp_we);
    chk_val("rd", rd, exp_rd);
    chk_val("Write_Data", Write_Data, exp_data);
    chk_val("lu_ready", lu_ready, exp_rdy);
    chk_val("stall_pipe", stall_pipe, m_stall);
    chk_val("pending_mask", pending_mask, exp_mask);
    chk_val("err_collision", err_collision, m_err);
    if (reset) begin
      mq.delete();
      m_run = 0; m_stall = 1'b0; m_err = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        if (!req) begin
          void'(mq.pop_front());
          m_run = 0; m_stall = 1'b0;
        end else if (m_stall) begin
          m_err = 1'b1;
        end else begin
          m_run++;
          if (m_run == MAXW) begin
            m_stall = 1'b1; m_run = 0;
          end
        end
      end
      if (lu_valid && exp_rdy && lu_rd != 5'd0) begin
        e.rd = lu_rd; e.data = lu_data;
        mq.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_stall(input string tag, input int exp_n);
    int n = 0;
    while (!stall_pipe && n < 20) begin
      step();
      n++;
    end
    chk_val(tag, n, exp_n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    step(); step();
    reset = 1'b0;
    #1;
    chk_val("rst_lu_ready", lu_ready, 1);
    chk_val("rst_mask", pending_mask, 0);
    step();

    // Primary write is same-cycle.
    wb_valid = 1; wb_rd = 5; wb_data = 64'hA5;
    #1;
    chk_val("t1_we", RegWrite, 1);
    chk_val("t1_rd", rd, 5);
    chk_val("t1_data", Write_Data, 64'hA5);
    step();
    wb_valid = 0;

    // Secondary push drains next cycle.
    lu_valid = 1; lu_rd = 3; lu_data = 64'h11;
    step();
    lu_valid = 0;
    #1;
    chk_val("t2_rd", rd, 3);
    chk_val("t2_mask", pending_mask, 32'h8);
    step();
    chk_val("t2_mask_clr", pending_mask, 0);

    // Starvation: forced bubble after MAXW denials.
    wb_valid = 1; wb_rd = 9; wb_data = {$urandom, $urandom};
    lu_valid = 1; lu_rd = 7; lu_data = {$urandom, $urandom};
    step();
    lu_valid = 0;
    wait_stall("t3_stall_delay", MAXW);
    wb_valid = 0;
    #1;
    chk_val("t3_rd", rd, 7);
    step();
    chk_val("t3_stall_clr", stall_pipe, 0);

    // Full FIFO backpressure and ordering.
    wb_valid = 1; wb_rd = 9;
    lu_valid = 1; lu_rd = 1; lu_data = 64'h101;
    step();
    lu_rd = 2; lu_data = 64'h202;
    step();
    lu_rd = 6; lu_data = 64'h606;
    #1;
    chk_val("t4_full_ready", lu_ready, 0);
    step();
    wb_valid = 0;
    #1;
    chk_val("t4_first", rd, 1);
    chk_val("t4_pop_ready", lu_ready, 0);
    step();
    chk_val("t4_second", rd, 2);
    chk_val("t4_ready_rise", lu_ready, 1);
    step();
    lu_valid = 0;
    #1;
    chk_val("t4_third", rd, 6);
    step();

    // x0 handling on both writers.
    lu_valid = 1; lu_rd = 0; lu_data = 64'hDEAD;
    #1;
    chk_val("t5_x0_ready", lu_ready, 1);
    step();
    lu_valid = 0;
    #1;
    chk_val("t5_x0_we", RegWrite, 0);
    chk_val("t5_x0_mask", pending_mask, 0);
    lu_valid = 1; lu_rd = 4; lu_data = 64'h44;
    step();
    lu_valid = 0; wb_valid = 1; wb_rd = 0; wb_data = 64'h99;
    #1;
    chk_val("t5_wbx0_rd", rd, 4);
    step();
    wb_valid = 0;

    // Collision during the forced bubble.
    wb_valid = 1; wb_rd = 10; wb_data = 64'hAAAA;
    lu_valid = 1; lu_rd = 8; lu_data = 64'h88;
    step();
    lu_valid = 0;
    wait_stall("t6_stall_delay", MAXW);
    #1;
    chk_val("t6_wb_wins", rd, 10);
    step();
    chk_val("t6_err", err_collision, 1);
    chk_val("t6_stall_held", stall_pipe, 1);
    wb_valid = 0;
    #1;
    chk_val("t6_head", rd, 8);
    step();
    chk_val("t6_err_sticky", err_collision, 1);

    // Reset with two queued entries.
    wb_valid = 1; wb_rd = 10;
    lu_valid = 1; lu_rd = 11; lu_data = 64'hB;
    step();
    lu_rd = 12; lu_data = 64'hC;
    step();
    lu_valid = 0; wb_valid = 0; reset = 1;
    #1;
    chk_val("t6_mask_q", pending_mask, 32'h1800);
    chk_val("t6_rst_we", RegWrite, 0);
    step();
    reset = 0;
    #1;
    chk_val("t6_post_ready", lu_ready, 1);
    chk_val("t6_post_mask", pending_mask, 0);
    chk_val("t6_post_we", RegWrite, 0);
    chk_val("t6_post_err", err_collision, 0);
    step();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      wb_valid = ($urandom_range(0, 9) < 6);
      if (m_stall && $urandom_range(0, 15) != 0) wb_valid = 0;
      wb_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data  = {$urandom, $urandom};
      lu_valid = $urandom_range(0, 1) == 1;
      lu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      lu_data  = {$urandom, $urandom};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (RegWrite/rd/Write_Data) between two writers: the pipeline writeback stage (primary) and a long-latency execution unit (secondary, e.g. mul/div).
- The primary writer always has priority. Secondary results are held in a small FIFO.
- A starvation FSM forces a one-cycle pipeline bubble so the secondary writer is guaranteed service.
- Exports a pending-register mask for the hazard unit.

Parameters:
- XLEN, 64, data width.
- FIFO_DEPTH, 2, secondary result FIFO entries (power of 2, >=2).
- MAX_WAIT, 4, number of consecutive denied cycles for a non-empty FIFO before a forced grant (>=1).

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- wb_valid  in  1  primary writeback request.
- wb_rd  in  5  primary destination register.
- wb_data  in  XLEN  primary write data.
- lu_valid  in  1  secondary result valid.
- lu_ready  out  1  secondary result accepted when lu_valid&&lu_ready.
- lu_rd  in  5  secondary destination register.
- lu_data  in  XLEN  secondary write data.
- RegWrite  out  1  register-file write enable.
- rd  out  5  register-file write address.
- Write_Data  out  XLEN  register-file write data.
- stall_pipe  out  1  registered; pipeline must present wb_valid=0 in any cycle this is high.
- pending_mask  out  32  bit r set while a FIFO entry targets xr.
- err_collision  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (sampled high at posedge):
  - FIFO empties; FSM goes to IDLE; wait_cnt=0.
  - stall_pipe=0, err_collision=0, pending_mask=0, RegWrite=0.
  - lu_ready=0 while reset is high; lu_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards queued entries; they are never written.
- Effective primary request: wb_req = wb_valid && (wb_rd != 0). A wb_valid with rd=x0 is an idle slot.
- Enqueue:
  - lu_ready = !full.
  - On lu_valid&&lu_ready with lu_rd != 0, push {lu_rd, lu_data}.
  - lu_rd = 0 is accepted and discarded (handshake completes, nothing pushed).
  - No same-cycle bypass: minimum latency from acceptance to RegWrite is 1 cycle.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - Since lu_ready depends on full only, a full FIFO never accepts a push, even if it pops that cycle.
- Port mux (combinational, same cycle as inputs):
  - If wb_req: RegWrite=1, rd=wb_rd, Write_Data=wb_data. The primary path adds zero latency.
  - Else if FIFO non-empty: RegWrite=1 with the head's rd/data, then pop.
  - Else RegWrite=0; rd and Write_Data are don't-care (drive 0).
- FSM states:
  - IDLE: FIFO empty, wait_cnt=0. Go to WAIT when an entry becomes present.
  - WAIT: each cycle with head present and no grant (wb_req=1), wait_cnt++.
    - Any grant clears wait_cnt.
    - When wait_cnt reaches MAX_WAIT-1 and the head is denied again, go to FORCE and set stall_pipe=1 (registered) for the next cycle.
    - Go to IDLE when the FIFO becomes empty.
  - FORCE: stall_pipe=1 for exactly one cycle; the head is granted.
    - Then go to WAIT if entries remain, else IDLE. wait_cnt=0.
    - If wb_req=1 during FORCE (protocol violation): the primary write wins, the head is held, err_collision is set, and the FSM stays in FORCE (stall_pipe stays 1) until the head is granted.
- pending_mask: the OR of one-hot(rd) over all valid FIFO entries.
  - Pushes and pops update it at the clock edge.
  - Duplicate rd entries keep the bit set until the last such entry pops. Implement as a per-register 2-bit count, or recompute from entries.
- Write ordering: FIFO entries retire in order. The WAW ordering between primary and secondary writers is the hazard unit's responsibility, using pending_mask.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH)+1 bits; full/empty is decided by MSB compare.

Decomposition:
- Shared package holds:
  - XLEN and the register-index width (5).
  - The FSM state enum {IDLE, WAIT, FORCE}.
  - The FIFO entry struct {rd[4:0], data[XLEN-1:0]}.
- One sub-module: regfile_wr_fifo (sync FIFO, push/pop/full/empty/head, plus a per-entry valid/rd view for pending_mask). The FSM and port mux stay in the top module.

Test Plan:
1. wb_valid=1, wb_rd=5, wb_data=0xA5 with FIFO empty -> same cycle RegWrite=1, rd=5, Write_Data=0xA5; stall_pipe=0.
2. lu push rd=3, data=0x11 with no wb -> next cycle RegWrite=1, rd=3; pending_mask bit3 is 1 for one cycle, then 0.
3. lu push rd=7 while wb_req=1 every cycle, MAX_WAIT=4 -> stall_pipe=1 on cycle 5 after push; bench drops wb_valid; rd=7 written that cycle; FSM returns to IDLE.
4. Two lu pushes (rd=1, rd=2) while wb busy -> lu_ready=0 at depth 2; lu_valid is held until a pop; lu_ready then rises and order 1, 2 is preserved.
5. lu push rd=0 -> handshake completes, pending_mask=0, RegWrite never asserted; wb_rd=0 with FIFO entry rd=4 -> rd=4 written that cycle.
6. wb_req=1 during a FORCE cycle -> wb written, err_collision=1 sticky, stall_pipe stays 1; reset mid-queue (2 entries) -> FIFO empty, no write of the queued entries, lu_ready=1 one cycle after reset drops.
